// File: rtl/freertos_multi_timer.sv
// Multi-channel down-counting interval timer with a memory-mapped register file.
// Each channel has a prescaler, reload period, timeout flag and counter snapshot.
module freertos_multi_timer #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  localparam int unsigned ADDR_W      = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CONTROL  = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAPSHOT = 2'd3;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
  logic [15:0]       presc_q  [NUM_CH];
  logic [15:0]       presc_d  [NUM_CH];
  logic [3:0]        psel_q   [NUM_CH];
  logic [3:0]        psel_d   [NUM_CH];
  logic [NUM_CH-1:0] to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
  logic [NUM_CH-1:0] reload_q, reload_d;
  logic [NUM_CH-1:0] wr_status, wr_ctrl, wr_period, wr_snap;
  logic [NUM_CH-1:0] tick, timeout, start, stop;
  logic [31:0]       rd_d;
  logic              wr_en;
  int unsigned       sel_ch;

  assign wr_en  = chipselect & ~write_n;
  assign sel_ch = 32'(address >> 2);
  assign irq    = |irq_vec;

  // Per-channel write strobes; addresses beyond the last channel decode to nothing.
  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_period = '0;
    wr_snap   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_status[i] = wr_en && (sel_ch == i) && (address[1:0] == REG_STATUS);
      wr_ctrl[i]   = wr_en && (sel_ch == i) && (address[1:0] == REG_CONTROL);
      wr_period[i] = wr_en && (sel_ch == i) && (address[1:0] == REG_PERIOD);
      wr_snap[i]   = wr_en && (sel_ch == i) && (address[1:0] == REG_SNAPSHOT);
    end
  end

  // Channel next-state: a pending PERIOD reload overrides counting and discards START.
  always_comb begin
    tick     = '0;
    timeout  = '0;
    start    = '0;
    stop     = '0;
    to_d     = to_q;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    reload_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      snap_d[i]   = snap_q[i];
      presc_d[i]  = presc_q[i];
      psel_d[i]   = psel_q[i];

      tick[i]     = run_q[i] && !reload_q[i] &&
                    (presc_q[i] == ((16'd1 << psel_q[i]) - 16'd1));
      timeout[i]  = tick[i] && (cnt_q[i] == '0);
      start[i]    = wr_ctrl[i] && writedata[2];
      stop[i]     = wr_ctrl[i] && writedata[3] && !writedata[2];
      reload_d[i] = wr_period[i];

      if (reload_q[i] || timeout[i]) begin
        cnt_d[i] = period_q[i];
      end else if (tick[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end

      if (reload_q[i] || start[i] || tick[i]) begin
        presc_d[i] = '0;
      end else if (run_q[i]) begin
        presc_d[i] = presc_q[i] + 16'd1;
      end

      if (reload_q[i]) begin
        run_d[i] = 1'b0;
      end else if (start[i]) begin
        run_d[i] = 1'b1;
      end else if (stop[i] || (timeout[i] && !cont_q[i])) begin
        run_d[i] = 1'b0;
      end

      if (timeout[i]) begin
        to_d[i] = 1'b1;
      end else if (wr_status[i]) begin
        to_d[i] = 1'b0;
      end

      if (wr_ctrl[i]) begin
        ito_d[i]  = writedata[0];
        cont_d[i] = writedata[1];
        psel_d[i] = writedata[7:4];
      end
      if (wr_period[i]) begin
        period_d[i] = CNT_W'(writedata);
      end
      if (wr_snap[i]) begin
        snap_d[i] = cnt_d[i];
      end
    end
  end

  // Read mux, sampled into readdata on the next edge.
  always_comb begin
    rd_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_ch == i) begin
        unique case (address[1:0])
          REG_STATUS:   rd_d = {30'd0, run_q[i], to_q[i]};
          REG_CONTROL:  rd_d = {24'd0, psel_q[i], 2'b00, cont_q[i], ito_q[i]};
          REG_PERIOD:   rd_d = 32'(period_q[i]);
          REG_SNAPSHOT: rd_d = 32'(snap_q[i]);
          default:      rd_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= CNT_W'(RESET_PERIOD);
        period_q[i] <= CNT_W'(RESET_PERIOD);
        snap_q[i]   <= '0;
        presc_q[i]  <= '0;
        psel_q[i]   <= '0;
      end
      to_q     <= '0;
      run_q    <= '0;
      ito_q    <= '0;
      cont_q   <= '0;
      reload_q <= '0;
      readdata <= '0;
      irq_vec  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        snap_q[i]   <= snap_d[i];
        presc_q[i]  <= presc_d[i];
        psel_q[i]   <= psel_d[i];
      end
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      reload_q <= reload_d;
      readdata <= rd_d;
      irq_vec  <= to_d & ito_d;
    end
  end

endmodule

// File: tb/tb_freertos_multi_timer.sv
// Directed and randomized checks of freertos_multi_timer against interval arithmetic
// and a shadow register model; three channels so an unimplemented channel is addressable.
module tb_freertos_multi_timer;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ADDR_W = $clog2(NUM_CH) + 2;
  localparam int unsigned RST_P  = 49999;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  int tests = 0;
  int fails = 0;

  freertos_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(32), .RESET_PERIOD(RST_P)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int ch, input int r);
    return ADDR_W'((ch << 2) | r);
  endfunction

  function automatic logic irq_of(input int ch);
    logic [7:0] v;
    v = 8'(irq_vec);
    return v[3'(ch)];
  endfunction

  // All bus tasks start and end just after a falling edge; each spans one rising edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    address    = addr_of(ch, r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    address    = addr_of(ch, r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Count edges from the START write to the TO-setting edge; interval should be (P+1)*2^S.
  task automatic measure(input int ch, input int p, input int s, input int cont);
    int n;
    int interval;
    logic [31:0] rd;
    interval = (p + 1) * (1 << s);
    bus_write(ch, 2, 32'(p));
    idle(1);
    bus_write(ch, 0, 32'd0);
    bus_write(ch, 1, 32'((s << 4) | 4 | (cont << 1) | 1));
    n = 0;
    while (!irq_of(ch) && n < 3000) begin
      idle(1);
      n++;
    end
    check($sformatf("interval1 ch%0d p%0d s%0d", ch, p, s), 32'(n), 32'(interval));
    if (cont != 0) begin
      bus_write(ch, 0, 32'd0);
      n++;
      check($sformatf("irq_clr ch%0d", ch), 32'(irq_of(ch)), 32'd0);
      while (!irq_of(ch) && n < 6000) begin
        idle(1);
        n++;
      end
      check($sformatf("interval2 ch%0d p%0d s%0d", ch, p, s), 32'(n), 32'(2 * interval));
    end else begin
      bus_read(ch, 0, rd);
      check($sformatf("oneshot_status ch%0d", ch), rd, 32'd1);
    end
    bus_write(ch, 1, 32'h8);
    bus_write(ch, 0, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] per_m [NUM_CH];
    logic [31:0] ctl_m [NUM_CH];
    int ch;

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    idle(3);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    reset = 1'b0;
    bus_read(0, 0, rd); check("rst_status0", rd, 32'd0);
    bus_read(0, 1, rd); check("rst_control0", rd, 32'd0);
    bus_read(1, 2, rd); check("rst_period1", rd, 32'(RST_P));
    bus_read(2, 3, rd); check("rst_snap2", rd, 32'd0);

    // Continuous mode: timeouts every PERIOD+1 cycles, cleared by STATUS writes.
    bus_write(0, 2, 32'd4); idle(1); bus_write(0, 0, 32'd0);
    bus_write(0, 1, 32'h07);
    idle(4); check("cont_t4", 32'(irq), 32'd0);
    idle(1); check("cont_t5", 32'(irq), 32'd1);
    check("cont_t5_vec", 32'(irq_vec), 32'd1);
    bus_write(0, 0, 32'd0); check("cont_t6_clr", 32'(irq), 32'd0);
    idle(3); check("cont_t9", 32'(irq), 32'd0);
    idle(1); check("cont_t10", 32'(irq), 32'd1);
    bus_write(0, 0, 32'd0);
    idle(3); check("cont_t14", 32'(irq), 32'd0);
    idle(1); check("cont_t15", 32'(irq), 32'd1);
    bus_write(0, 1, 32'h08); bus_write(0, 0, 32'd0);

    // One-shot on channel 1.
    bus_write(1, 2, 32'd3); idle(1); bus_write(1, 0, 32'd0);
    bus_write(1, 1, 32'h05);
    idle(3); check("oneshot_t3", 32'(irq_of(1)), 32'd0);
    idle(1); check("oneshot_t4", 32'(irq_of(1)), 32'd1);
    bus_read(1, 0, rd); check("oneshot_status", rd, 32'd1);
    bus_write(1, 3, 32'd0);
    bus_read(1, 3, rd); check("oneshot_snap", rd, 32'd3);
    bus_write(1, 0, 32'd0);
    idle(10); check("oneshot_no_more", 32'(irq_of(1)), 32'd0);

    // Prescaled channel: PSEL=2, PERIOD=1 gives 8-cycle intervals.
    measure(0, 1, 2, 1);

    // STATUS write colliding with a timeout leaves TO set.
    bus_write(0, 2, 32'd3); idle(1); bus_write(0, 0, 32'd0);
    bus_write(0, 1, 32'h07);
    idle(4); check("coll_t4", 32'(irq_of(0)), 32'd1);
    bus_write(0, 0, 32'd0); check("coll_t5_clr", 32'(irq_of(0)), 32'd0);
    idle(2);
    bus_write(0, 0, 32'd0); check("coll_t8_irq", 32'(irq_of(0)), 32'd1);
    bus_read(0, 0, rd); check("coll_status", rd, 32'd3);
    bus_write(0, 1, 32'h08);
    bus_write(0, 1, 32'h0C);
    bus_read(0, 0, rd); check("start_stop_run", (rd >> 1) & 32'd1, 32'd1);
    bus_write(0, 1, 32'h08); bus_write(0, 0, 32'd0);

    // START landing on the reload cycle after a PERIOD write is discarded.
    bus_write(0, 2, 32'd20);
    bus_write(0, 1, 32'h04);
    bus_read(0, 0, rd); check("reload_start_run", (rd >> 1) & 32'd1, 32'd0);
    bus_write(0, 1, 32'h04);
    bus_read(0, 0, rd); check("late_start_run", (rd >> 1) & 32'd1, 32'd1);
    bus_write(0, 1, 32'h08);

    // Snapshot ten edges after START with PERIOD=100.
    bus_write(0, 2, 32'd100); idle(1);
    bus_write(0, 1, 32'h04);
    idle(9);
    bus_write(0, 3, 32'd0);
    bus_read(0, 3, rd); check("snap_90", rd, 32'd90);
    bus_write(0, 1, 32'h08);

    // Random register readback against a shadow model.
    for (int k = 0; k < 4; k++) begin
      ch = int'($urandom_range(0, NUM_CH - 1));
      per_m[ch] = $urandom;
      ctl_m[ch] = $urandom & 32'hF3;
      bus_write(ch, 2, per_m[ch]);
      bus_write(ch, 1, ctl_m[ch]);
      bus_read(ch, 2, rd); check($sformatf("rb_period ch%0d", ch), rd, per_m[ch]);
      bus_read(ch, 1, rd); check($sformatf("rb_control ch%0d", ch), rd, ctl_m[ch]);
    end

    // Random timeout intervals.
    for (int k = 0; k < 6; k++) begin
      measure(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(1, 20)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    // Reset mid-count with irq high, with a bus write in the reset cycle.
    bus_write(1, 2, 32'd2); idle(1); bus_write(1, 0, 32'd0);
    bus_write(1, 1, 32'h07);
    idle(5); check("pre_reset_irq", 32'(irq), 32'd1);
    reset = 1'b1; address = addr_of(0, 2); writedata = 32'd7;
    chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("mid_reset_irq", 32'(irq), 32'd0);
    check("mid_reset_readdata", readdata, 32'd0);
    bus_read(1, 0, rd); check("mid_reset_status1", rd, 32'd0);
    bus_read(0, 2, rd); check("mid_reset_period0", rd, 32'(RST_P));
    idle(6); check("post_reset_quiet", 32'(irq), 32'd0);
    bus_write(3, 2, 32'd5);
    bus_read(3, 2, rd); check("oor_period", rd, 32'd0);
    bus_read(3, 0, rd); check("oor_status", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
